// File: rtl/divider_8b.sv
// divider_8b: sequential radix-2 restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and returns the quotient
// and remainder. Handshakes use valid/ready on both sides.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     operands valid
//   in_ready     block can accept operands (IDLE only)
//   dividend     2*WIDTH-bit unsigned numerator
//   divisor      WIDTH-bit unsigned denominator
//   out_valid    result valid (DONE only)
//   out_ready    consumer takes the result
//   quotient     2*WIDTH-bit unsigned quotient (all ones on divide by zero)
//   remainder    WIDTH-bit unsigned remainder (dividend low bits on divide by zero)
//   div_by_zero  result flag: divisor was zero
module divider_8b #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int unsigned QW = 2 * WIDTH;
    localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  d_q;
    logic [QW-1:0]     q_q;
    logic [WIDTH-1:0]  r_q;
    logic [CW-1:0]     cnt_q;

    logic [WIDTH:0]    t_d;
    logic [WIDTH:0]    diff_d;
    logic              ge_d;
    logic [WIDTH-1:0]  r_d;
    logic [QW-1:0]     q_d;

    // R < D before every shift, so the partial remainder always fits in WIDTH
    // bits; only the shifted trial value T and the subtract need WIDTH+1 bits.
    // The top bit of the difference is therefore always zero when it is kept.
    logic              unused_diff_msb;

    always_comb begin
        t_d    = {r_q, q_q[QW-1]};
        diff_d = t_d - {1'b0, d_q};
        ge_d   = (t_d >= {1'b0, d_q});
        r_d    = ge_d ? diff_d[WIDTH-1:0] : t_d[WIDTH-1:0];
        q_d    = {q_q[QW-2:0], ge_d};
    end

    assign unused_diff_msb = diff_d[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        d_q      <= divisor;
                        q_q      <= dividend;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        if (divisor != '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q     <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[WIDTH-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= q_d;
                        remainder   <= r_d;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8b.sv
// Directed testbench for divider_8b (WIDTH=4) with hand-computed expectations.
module tb_divider_8b;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    divider_8b #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Accept one operand pair and return the number of edges after the accept
    // edge until out_valid is seen.
    task automatic launch(input logic [7:0] dvd, input logic [3:0] dvs, output int edges);
        wait_ready();
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic divide(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                          input logic [7:0] eq, input logic [3:0] er, input logic ez,
                          input int elat);
        int edges;
        launch(dvd, dvs, edges);
        check({tag, "_lat"}, 32'(edges), 32'(elat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_z"}, 32'(div_by_zero), 32'(ez));
        check({tag, "_inrdy_busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int edges;
        int ov_seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_z", 32'(div_by_zero), 32'd0);

        // Basic and edge values
        divide("d143_11", 8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 8);
        divide("d200_7",  8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8);
        divide("d255_15", 8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8);
        divide("d5_9",    8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8);
        divide("d255_1",  8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8);
        divide("d0_3",    8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 8);

        // Divide by zero: result visible right after the accept edge
        divide("dz",      8'hA6,  4'd0,  8'hFF,  4'h6, 1'b1, 0);

        // Back-pressure with an ignored in_valid pulse
        launch(8'd143, 4'd11, edges);
        check("bp_lat", 32'(edges), 32'd8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                dividend = 8'd99;
                divisor  = 4'd3;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_inrdy", 32'(in_ready), 32'd0);
            check("bp_q", 32'(quotient), 32'd13);
            check("bp_r", 32'(remainder), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 32'(in_ready), 32'd1);
        divide("d99_3", 8'd99, 4'd3, 8'd33, 4'd0, 1'b0, 8);

        // Reset during iteration 4 of 200/7
        wait_ready();
        dividend = 8'd200;
        divisor  = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_q", 32'(quotient), 32'd0);
        check("mrst_r", 32'(remainder), 32'd0);
        check("mrst_z", 32'(div_by_zero), 32'd0);
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) ov_seen = 1;
        end
        check("mrst_no_ov", 32'(ov_seen), 32'd0);
        divide("d200_7b", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);

        // Inverse of multiplication, back-to-back with out_ready held high
        out_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                logic [7:0] prod;
                int gap;
                prod = 8'(x * y);
                wait_ready();
                gap = int'($urandom_range(2, 0));
                for (int g = 0; g < gap; g++) tick();
                dividend = prod;
                divisor  = 4'(y);
                in_valid = 1'b1;
                tick();
                in_valid = 1'b0;
                edges = 0;
                while (!out_valid && edges < 40) begin
                    tick();
                    edges++;
                end
                check("inv_lat", 32'(edges), 32'd8);
                check("inv_q", 32'(quotient), 32'(x));
                check("inv_r", 32'(remainder), 32'd0);
                tick();
            end
        end
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
